register_bank: RTL and testbench
================================

REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits (>=2).
REQ-002 SHALL have parameter DEPTH, default 8, number of registers (power of 2, >=2); AW = $clog2(DEPTH).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 we  input  1  write strobe, sampled on rising clk.
REQ-007 op  input  2  write operation: LOAD, RSUB, CLR1, HOLD.
REQ-008 waddr  input  AW  write/operate target index.
REQ-009 wdata  input  WIDTH signed  write operand.
REQ-010 raddr_a, raddr_b  input  AW each  read indices.
REQ-011 rdata_a, rdata_b  output  WIDTH signed each  registered read data.
REQ-012 borrow  output  1  sticky flag from the most recent RSUB.
REQ-013 clr_all  input  1  request to zero the whole bank.
REQ-014 busy  output  1  high while the bank clear sequence runs.

Function
REQ-015 SHALL hold DEPTH signed WIDTH-bit registers; a register changes only through REQ-016..019 or reset.
REQ-016 LOAD with we=1: reg[waddr] <= wdata at the next edge.
REQ-017 RSUB with we=1: reg[waddr] <= wdata - reg[waddr], truncated to WIDTH (two's-complement wrap); borrow <= 1 when the WIDTH+1-bit signed difference is negative, else 0.
REQ-018 CLR1 with we=1: reg[waddr] <= 0; borrow unchanged.
REQ-019 HOLD, or we=0: no register change; borrow unchanged.
REQ-020 borrow SHALL change only on an accepted RSUB.
REQ-021 Reads: rdata_x <= value of reg[raddr_x] after the same edge's write (write-first bypass); latency is exactly 1 cycle.
REQ-022 Bypass SHALL apply to both ports simultaneously and to every op, including the RSUB result.
REQ-023 FSM states IDLE, CLEAR; IDLE -> CLEAR when clr_all=1; CLEAR zeroes one register per cycle, index 0 to DEPTH-1, and returns to IDLE after index DEPTH-1.
REQ-024 busy = 1 exactly in CLEAR, i.e. for DEPTH cycles; the clear clears borrow on entry.
REQ-025 While busy, we SHALL be ignored (write dropped, no queuing); clr_all SHALL be ignored.
REQ-026 While busy, reads SHALL follow REQ-021 with the clear write as the bypassed write.
REQ-027 clr_all and we in the same IDLE cycle: the write is applied first, then clearing starts on the next cycle.
REQ-028 The clear index counter SHALL wrap to 0 on exit.

Reset
REQ-029 On rst=0, all registers, rdata_a, rdata_b, borrow and the clear counter SHALL go to 0 and the FSM SHALL go to IDLE immediately, regardless of clk.
REQ-030 Reset asserted during CLEAR SHALL abort the sequence; busy=0 after release.
REQ-031 The first write SHALL be accepted at the first rising edge after rst deasserts.

Structure
REQ-032 A shared package register_pkg SHALL hold the op enum (LOAD=2'b00, RSUB=2'b01, CLR1=2'b10, HOLD=2'b11) and the FSM state enum.
REQ-033 The RSUB arithmetic and borrow SHALL sit in one combinational sub-module, rsub_unit (WIDTH parameter).
REQ-034 Storage SHALL be a flip-flop array; no memory macros.

Verification (WIDTH=8, DEPTH=8)
REQ-035 Reset, then read all 8 indices -> every rdata is 0 and borrow=0.
REQ-036 LOAD r3=25, then RSUB r3 with wdata=10 -> r3=-15, borrow=1; then RSUB r3 with wdata=-15 -> r3=0, borrow=0.
REQ-037 RSUB r1 with r1=127 and wdata=-128 -> r1=1 (wrap), borrow=1.
REQ-038 LOAD r5=42 with raddr_a=raddr_b=5 in the same cycle -> both ports show 42 one cycle later.
REQ-039 Load r0..r7 with nonzero values, pulse clr_all together with LOAD r2=9 -> busy high for exactly 8 cycles; writes issued during busy are dropped; all registers end at 0.
REQ-040 Assert rst at cycle 3 of CLEAR -> busy=0, all registers 0 and FSM in IDLE immediately.

Source files
------------

// File: rtl/register_pkg.sv
// Shared types for the register bank: write-operation encoding and
// clear-sequencer state.
package register_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'b00,
    RSUB = 2'b01,
    CLR1 = 2'b10,
    HOLD = 2'b11
  } op_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/rsub_unit.sv
// Reverse subtract: diff = a - b wrapped to WIDTH bits; borrow is the sign
// of the exact WIDTH+1-bit signed difference.
module rsub_unit #(
  parameter int WIDTH = 8
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] diff,
  output logic                    borrow
);

  logic signed [WIDTH:0] full_s;

  // Sign-extend both operands so the extra bit carries the true sign
  always_comb begin
    full_s = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    diff   = full_s[WIDTH-1:0];
    borrow = full_s[WIDTH];
  end

endmodule

// File: rtl/register_bank.sv
// Flip-flop register bank with load / reverse-subtract / clear-one ops,
// write-first registered read ports and a one-register-per-cycle bank clear.
module register_bank
  import register_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [1:0]              op,
  input  logic [AW-1:0]           waddr,
  input  logic signed [WIDTH-1:0] wdata,
  input  logic [AW-1:0]           raddr_a,
  input  logic [AW-1:0]           raddr_b,
  output logic signed [WIDTH-1:0] rdata_a,
  output logic signed [WIDTH-1:0] rdata_b,
  output logic                    borrow,
  input  logic                    clr_all,
  output logic                    busy
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t                  state_r;
  state_t                  state_next_s;
  logic [AW-1:0]           cnt_r;
  logic                    busy_s;
  logic                    clear_wen_s;
  logic                    clear_start_s;
  logic signed [WIDTH-1:0] regs_r [DEPTH];
  logic                    wen_s;
  logic [AW-1:0]           widx_s;
  logic signed [WIDTH-1:0] wval_s;
  logic                    rsub_s;
  logic signed [WIDTH-1:0] sub_diff_s;
  logic                    sub_borrow_s;
  logic                    borrow_r;

  rsub_unit #(.WIDTH(WIDTH)) u_rsub (
    .a      (wdata),
    .b      (regs_r[waddr]),
    .diff   (sub_diff_s),
    .borrow (sub_borrow_s)
  );

  // Clear-sequencer state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_next_s;
  end

  // Clear-sequencer next state; clr_all is only honoured from IDLE
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (clr_all) state_next_s = CLEAR;
        else         state_next_s = IDLE;
      end
      CLEAR: begin
        if (cnt_r == LAST_IDX) state_next_s = IDLE;
        else                   state_next_s = CLEAR;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Clear-sequencer outputs
  always_comb begin
    busy_s        = 1'b0;
    clear_wen_s   = 1'b0;
    clear_start_s = 1'b0;
    case (state_r)
      IDLE: begin
        busy_s        = 1'b0;
        clear_wen_s   = 1'b0;
        clear_start_s = clr_all;
      end
      CLEAR: begin
        busy_s        = 1'b1;
        clear_wen_s   = 1'b1;
        clear_start_s = 1'b0;
      end
      default: begin
        busy_s        = 1'b0;
        clear_wen_s   = 1'b0;
        clear_start_s = 1'b0;
      end
    endcase
  end

  // Clear index, wrapping back to 0 as the sequence finishes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (clear_wen_s) begin
      if (cnt_r == LAST_IDX) cnt_r <= '0;
      else                   cnt_r <= cnt_r + AW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Single write port: the clear sequence owns it while busy, user writes are dropped
  always_comb begin
    wen_s  = 1'b0;
    widx_s = waddr;
    wval_s = '0;
    rsub_s = 1'b0;
    if (clear_wen_s) begin
      wen_s  = 1'b1;
      widx_s = cnt_r;
      wval_s = '0;
    end else if (we) begin
      case (op_t'(op))
        LOAD: begin
          wen_s  = 1'b1;
          wval_s = wdata;
        end
        RSUB: begin
          wen_s  = 1'b1;
          wval_s = sub_diff_s;
          rsub_s = 1'b1;
        end
        CLR1: begin
          wen_s  = 1'b1;
          wval_s = '0;
        end
        HOLD:    wen_s = 1'b0;
        default: wen_s = 1'b0;
      endcase
    end else begin
      wen_s = 1'b0;
    end
  end

  // Register storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs_r[i] <= '0;
    end else if (wen_s) begin
      regs_r[widx_s] <= wval_s;
    end
  end

  // Borrow flag; a same-cycle RSUB is applied first, so starting a clear wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               borrow_r <= 1'b0;
    else if (clear_start_s) borrow_r <= 1'b0;
    else if (rsub_s)        borrow_r <= sub_borrow_s;
  end

  // Registered read ports with write-first bypass
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      rdata_a <= (wen_s && (widx_s == raddr_a)) ? wval_s : regs_r[raddr_a];
      rdata_b <= (wen_s && (widx_s == raddr_b)) ? wval_s : regs_r[raddr_b];
    end
  end

  assign borrow = borrow_r;
  assign busy   = busy_s;

endmodule

// File: tb/tb_register_bank.sv
// Scoreboard bench for register_bank (WIDTH=8, DEPTH=8): stimulus pushes
// hand-computed expectations, a monitor pops one per clock and compares.
module tb_register_bank;

  logic              clk = 1'b0;
  logic              rst;
  logic              we;
  logic [1:0]        op;
  logic [2:0]        waddr;
  logic signed [7:0] wdata;
  logic [2:0]        raddr_a;
  logic [2:0]        raddr_b;
  logic signed [7:0] rdata_a;
  logic signed [7:0] rdata_b;
  logic              borrow;
  logic              clr_all;
  logic              busy;

  localparam logic [1:0] LD = 2'b00;
  localparam logic [1:0] RS = 2'b01;
  localparam logic [1:0] C1 = 2'b10;
  localparam logic [1:0] HD = 2'b11;

  typedef struct {
    string      tag;
    bit         ca;
    logic [7:0] ea;
    bit         cb;
    logic [7:0] eb;
    bit         cbr;
    logic       ebr;
    logic       ebz;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] init_v [8];
  logic [7:0] exp_b;
  int         idx;

  register_bank #(.WIDTH(8), .DEPTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .op      (op),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (raddr_a),
    .raddr_b (raddr_b),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .borrow  (borrow),
    .clr_all (clr_all),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus from a negedge and queue its expected result
  task automatic step(input string tag, input logic w, input logic [1:0] o,
                      input logic [2:0] wa, input logic [7:0] wd,
                      input logic [2:0] ra, input logic [2:0] rb, input logic clr,
                      input bit ca, input logic [7:0] ea, input bit cb, input logic [7:0] eb,
                      input bit cbr, input logic ebr, input logic ebz);
    exp_t e;
    we = w; op = o; waddr = wa; wdata = wd;
    raddr_a = ra; raddr_b = rb; clr_all = clr;
    e.tag = tag; e.ca = ca; e.ea = ea; e.cb = cb; e.eb = eb;
    e.cbr = cbr; e.ebr = ebr; e.ebz = ebz;
    q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: outputs settle 1 time unit after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        if (e.ca)  chk({e.tag, ".rdata_a"}, rdata_a, e.ea);
        if (e.cb)  chk({e.tag, ".rdata_b"}, rdata_b, e.eb);
        if (e.cbr) chk({e.tag, ".borrow"}, {7'd0, borrow}, {7'd0, e.ebr});
        chk({e.tag, ".busy"}, {7'd0, busy}, {7'd0, e.ebz});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; we = 1'b0; op = LD; waddr = 3'd0; wdata = 8'sd0;
    raddr_a = 3'd0; raddr_b = 3'd0; clr_all = 1'b0;
    #1;
    chk("por.rdata_a", rdata_a, 8'h00);
    chk("por.rdata_b", rdata_b, 8'h00);
    chk("por.borrow", {7'd0, borrow}, 8'h00);
    chk("por.busy", {7'd0, busy}, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++)
      step($sformatf("rd%0d", i), 1'b0, LD, 3'(i), 8'h00, 3'(i), 3'(7 - i), 1'b0,
           1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);

    step("ld_r3",     1'b1, LD, 3'd3, 8'h19, 3'd3, 3'd3, 1'b0, 1'b1, 8'h19, 1'b1, 8'h19, 1'b1, 1'b0, 1'b0);
    step("rsub_r3_a", 1'b1, RS, 3'd3, 8'h0A, 3'd3, 3'd3, 1'b0, 1'b1, 8'hF1, 1'b1, 8'hF1, 1'b1, 1'b1, 1'b0);
    step("rsub_r3_b", 1'b1, RS, 3'd3, 8'hF1, 3'd3, 3'd0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step("ld_r1",     1'b1, LD, 3'd1, 8'h7F, 3'd1, 3'd0, 1'b0, 1'b1, 8'h7F, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step("rsub_wrap", 1'b1, RS, 3'd1, 8'h80, 3'd1, 3'd1, 1'b0, 1'b1, 8'h01, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0);
    step("hold",      1'b1, HD, 3'd1, 8'h37, 3'd1, 3'd0, 1'b0, 1'b1, 8'h01, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    step("clr1_r1",   1'b1, C1, 3'd1, 8'h37, 3'd1, 3'd3, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    step("ld_r5_dual",1'b1, LD, 3'd5, 8'h2A, 3'd5, 3'd5, 1'b0, 1'b1, 8'h2A, 1'b1, 8'h2A, 1'b1, 1'b1, 1'b0);
    step("we0",       1'b0, LD, 3'd5, 8'h63, 3'd5, 3'd1, 1'b0, 1'b1, 8'h2A, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      init_v[i] = 8'(8'h11 * (i + 1));
      step($sformatf("fill%0d", i), 1'b1, LD, 3'(i), init_v[i], 3'(i), 3'(i), 1'b0,
           1'b1, init_v[i], 1'b1, init_v[i], 1'b1, 1'b1, 1'b0);
    end

    // Write lands first, then the clear starts and drops borrow
    step("clr_start", 1'b1, LD, 3'd2, 8'h09, 3'd2, 3'd3, 1'b1, 1'b1, 8'h09, 1'b1, 8'h44, 1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 8; c++) begin
      idx = (c + 1) % 8;
      if (idx == 0)      exp_b = 8'h00;
      else if (idx == 2) exp_b = 8'h09;
      else               exp_b = init_v[idx];
      step($sformatf("clr%0d", c), 1'b1, LD, 3'((c + 2) % 8), 8'h5A, 3'(c), 3'(idx), 1'b1,
           1'b1, 8'h00, 1'b1, exp_b, 1'b1, 1'b0, (c < 7) ? 1'b1 : 1'b0);
    end
    for (int i = 0; i < 8; i++)
      step($sformatf("post%0d", i), 1'b0, LD, 3'd0, 8'h00, 3'(i), 3'(7 - i), 1'b0,
           1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);

    step("pre_ld5",  1'b1, LD, 3'd5, 8'h55, 3'd5, 3'd0, 1'b0, 1'b1, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    step("pre_ld6",  1'b1, LD, 3'd6, 8'h66, 3'd6, 3'd5, 1'b0, 1'b1, 8'h66, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    step("pre_rs7",  1'b1, RS, 3'd7, 8'hFF, 3'd7, 3'd6, 1'b0, 1'b1, 8'hFF, 1'b1, 8'h66, 1'b1, 1'b1, 1'b0);
    step("clr2_go",  1'b0, LD, 3'd0, 8'h00, 3'd5, 3'd6, 1'b1, 1'b1, 8'h55, 1'b1, 8'h66, 1'b1, 1'b0, 1'b1);
    step("clr2_c0",  1'b0, LD, 3'd0, 8'h00, 3'd6, 3'd7, 1'b0, 1'b1, 8'h66, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
    step("clr2_c1",  1'b0, LD, 3'd0, 8'h00, 3'd6, 3'd7, 1'b0, 1'b1, 8'h66, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);

    // Third CLEAR cycle: reset takes effect without a clock edge
    rst = 1'b0;
    #1;
    chk("abort.busy", {7'd0, busy}, 8'h00);
    chk("abort.rdata_a", rdata_a, 8'h00);
    chk("abort.rdata_b", rdata_b, 8'h00);
    chk("abort.state_idle", {7'd0, dut.state_r}, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    step("first_wr", 1'b1, LD, 3'd4, 8'h4D, 3'd4, 3'd6, 1'b0, 1'b1, 8'h4D, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    step("rd_r4",    1'b0, LD, 3'd0, 8'h00, 3'd4, 3'd5, 1'b0, 1'b1, 8'h4D, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    step("rd_r7",    1'b0, LD, 3'd0, 8'h00, 3'd7, 3'd2, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
